// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter for the single-ported data memory.
// The winning command is latched into the dm drive registers, so the dm sees only registered state.
module dm_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 32,
    parameter bit FIRST_RR = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req0,
    input  logic          i_wr0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_gnt0,
    output logic          o_rvalid0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_wr1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_gnt1,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata1,
    output logic [AW-1:0] o_dm_addr,
    output logic          o_dm_rd,
    output logic          o_dm_wr,
    output logic [DW-1:0] o_dm_wdata,
    input  logic [DW-1:0] i_dm_rdata
);
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
    state_t        r_state;
    logic          r_rr;
    logic          r_dm_rd;
    logic          r_dm_wr;
    logic [AW-1:0] r_dm_addr;
    logic [DW-1:0] r_dm_wdata;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          w_pick0;
    logic          w_pick1;
    // the port being served ignores its own still-held request on exit
    always_comb begin
        w_pick0 = (r_state == IDLE) ? i_req0 & (~i_req1 | ~r_rr) : (r_state == SERVE1) & i_req0;
        w_pick1 = (r_state == IDLE) ? i_req1 & (~i_req0 | r_rr) : (r_state == SERVE0) & i_req1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr       <= FIRST_RR;
            r_dm_rd    <= 1'b0;
            r_dm_wr    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_state   <= w_pick0 ? SERVE0 : w_pick1 ? SERVE1 : IDLE;
            r_dm_wr   <= w_pick0 ? i_wr0 : w_pick1 & i_wr1;
            r_dm_rd   <= w_pick0 ? ~i_wr0 : w_pick1 & ~i_wr1;
            if (w_pick0 | w_pick1) begin
                r_dm_addr  <= w_pick0 ? i_addr0 : i_addr1;
                r_dm_wdata <= w_pick0 ? i_wdata0 : i_wdata1;
            end
            r_rvalid0 <= (r_state == SERVE0) & r_dm_rd;
            r_rvalid1 <= (r_state == SERVE1) & r_dm_rd;
            if ((r_state == SERVE0) & r_dm_rd)
                r_rdata0 <= i_dm_rdata;
            if ((r_state == SERVE1) & r_dm_rd)
                r_rdata1 <= i_dm_rdata;
            if (r_state == SERVE0)
                r_rr <= 1'b1;
            else if (r_state == SERVE1)
                r_rr <= 1'b0;
        end
    end
    assign o_gnt0     = (r_state == SERVE0);
    assign o_gnt1     = (r_state == SERVE1);
    assign o_rvalid0  = r_rvalid0;
    assign o_rvalid1  = r_rvalid1;
    assign o_rdata0   = r_rdata0;
    assign o_rdata1   = r_rdata1;
    assign o_dm_addr  = r_dm_addr;
    assign o_dm_rd    = r_dm_rd;
    assign o_dm_wr    = r_dm_wr;
    assign o_dm_wdata = r_dm_wdata;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus a randomized two-port traffic run checked
// against a transaction-level memory scoreboard.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [6:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, dm_rd, dm_wr;
    logic [31:0] rdata0, rdata1, dm_wdata, dm_rdata;
    logic [6:0]  dm_addr;
    logic [31:0] mem [128] = '{default: 32'h0};
    logic [31:0] ref_mem [128] = '{default: 32'h0};
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    logic [31:0] va, vb;
    int checks = 0, errors = 0;

    logic        act [2];
    logic        cw [2];
    logic [6:0]  ca [2];
    logic [31:0] cd [2];
    int          dly [2];
    int          waitc [2];
    logic        pend [2];
    logic [31:0] pdat [2];
    logic        sg [2];
    logic        sv [2];
    logic [31:0] sr [2];

    always #5 clk = ~clk;

    dm_arbiter #(.AW(7), .DW(32), .FIRST_RR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0(req0), .i_wr0(wr0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_gnt0(gnt0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .i_req1(req1), .i_wr1(wr1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_gnt1(gnt1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_dm_addr(dm_addr), .o_dm_rd(dm_rd), .o_dm_wr(dm_wr),
        .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata)
    );

    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b1; wr0 = 1'b1; addr0 = 7'h01; wdata0 = 32'hA5A5_0001;
        repeat (2) step();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, dm_rd, dm_wr} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, dm_rd, dm_wr});
        end
        checks++;
        if (dm_addr !== 7'h0 || dm_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_dm: got addr=%h wdata=%h want 0", dm_addr, dm_wdata);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h want 0", rdata0, rdata1);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || dm_wr !== 1'b1 || dm_addr !== 7'h01) begin
            errors++; $display("FAIL reset_release: got gnt0=%b wr=%b addr=%h want 1 1 01", gnt0, dm_wr, dm_addr);
        end
        req0 = 1'b0;
        ref_mem[1] = 32'hA5A5_0001;
        step();
        checks++;
        if (gnt0 !== 1'b0 || dm_wr !== 1'b0) begin
            errors++; $display("FAIL reset_pulse: got gnt0=%b wr=%b want 0 0", gnt0, dm_wr);
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; wr0 = 1'b1; addr0 = 7'h05; wdata0 = 32'hDEAD_BEEF;
        step();
        checks++;
        if (gnt0 !== 1'b1 || dm_wr !== 1'b1 || dm_rd !== 1'b0 || dm_addr !== 7'h05 || dm_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_gnt: got gnt0=%b wr=%b rd=%b addr=%h wd=%h", gnt0, dm_wr, dm_rd, dm_addr, dm_wdata);
        end
        req0 = 1'b0;
        ref_mem[5] = 32'hDEAD_BEEF;
        step();
        checks++;
        if (gnt0 !== 1'b0 || dm_wr !== 1'b0) begin
            errors++; $display("FAIL wr_idle: got gnt0=%b wr=%b want 0 0", gnt0, dm_wr);
        end
        req0 = 1'b1; wr0 = 1'b0;
        step();
        checks++;
        if (gnt0 !== 1'b1 || dm_rd !== 1'b1 || dm_wr !== 1'b0 || dm_addr !== 7'h05) begin
            errors++; $display("FAIL rd_gnt: got gnt0=%b rd=%b wr=%b addr=%h", gnt0, dm_rd, dm_wr, dm_addr);
        end
        req0 = 1'b0;
        exp_rd0 = ref_mem[5];
        step();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== exp_rd0 || gnt0 !== 1'b0) begin
            errors++; $display("FAIL rd_data: got rvalid0=%b rdata0=%h want 1 %h", rvalid0, rdata0, exp_rd0);
        end
        step();
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== exp_rd0) begin
            errors++; $display("FAIL rd_hold: got rvalid0=%b rdata0=%h want 0 %h", rvalid0, rdata0, exp_rd0);
        end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        va = $urandom; vb = ~va;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 7'h20; wdata0 = va;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 7'h21; wdata1 = vb;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || dm_addr !== ((i % 2 == 0) ? 7'h20 : 7'h21)
                || dm_wdata !== ((i % 2 == 0) ? va : vb)) begin
                errors++; $display("FAIL rr_seq%0d: got gnt=%b addr=%h wd=%h", i, {gnt0, gnt1}, dm_addr, dm_wdata);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_mem[7'h20] = va; ref_mem[7'h21] = vb;
        step();
        checks++;
        if ({gnt0, gnt1, dm_wr} !== 3'b0) begin
            errors++; $display("FAIL rr_idle: got %b want 000", {gnt0, gnt1, dm_wr});
        end
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'h21;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'h20;
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL rr_rd_first: got gnt=%b want 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        exp_rd0 = ref_mem[7'h21];
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b01 || rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== exp_rd0) begin
            errors++; $display("FAIL rr_rd_second: got gnt=%b rv=%b%b rdata0=%h want 01 10 %h", {gnt0, gnt1}, rvalid0, rvalid1, rdata0, exp_rd0);
        end
        req1 = 1'b0;
        exp_rd1 = ref_mem[7'h20];
        step();
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== exp_rd1) begin
            errors++; $display("FAIL rr_rd_data1: got rv=%b%b rdata1=%h want 01 %h", rvalid0, rvalid1, rdata1, exp_rd1);
        end
    endtask

    task automatic test_p1_read();
        va = $urandom;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 7'h7F; wdata0 = va;
        step();
        req0 = 1'b0;
        ref_mem[7'h7F] = va;
        step();
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'h7F;
        step();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || dm_rd !== 1'b1 || dm_wr !== 1'b0 || dm_addr !== 7'h7F) begin
            errors++; $display("FAIL p1_rd_gnt: got gnt=%b%b rd=%b wr=%b addr=%h", gnt0, gnt1, dm_rd, dm_wr, dm_addr);
        end
        req1 = 1'b0;
        exp_rd1 = ref_mem[7'h7F];
        step();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== exp_rd1 || rvalid0 !== 1'b0 || rdata0 !== exp_rd0) begin
            errors++; $display("FAIL p1_rd_data: got rv1=%b rdata1=%h rdata0=%h want 1 %h %h", rvalid1, rdata1, rdata0, exp_rd1, exp_rd0);
        end
        checks++;
        if (dm_rd !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL p1_rd_once: got rd=%b gnt1=%b want 0 0", dm_rd, gnt1);
        end
    endtask

    task automatic test_reset_mid();
        va = $urandom;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 7'h10; wdata1 = va;
        step();
        req1 = 1'b0;
        ref_mem[7'h10] = va;
        step();
        req1 = 1'b1; wr1 = 1'b1; addr1 = 7'h10; wdata1 = 32'h1234_5678;
        step();
        checks++;
        if (gnt1 !== 1'b1 || dm_wr !== 1'b1) begin
            errors++; $display("FAIL midrst_gnt: got gnt1=%b wr=%b want 1 1", gnt1, dm_wr);
        end
        #2 rst_n = 1'b0; req1 = 1'b0;
        #1;
        checks++;
        if (dm_wr !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got wr=%b gnt1=%b want 0 0", dm_wr, gnt1);
        end
        @(negedge clk);
        rst_n = 1'b1; exp_rd0 = '0; exp_rd1 = '0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 7'h10;
        step();
        req1 = 1'b0;
        exp_rd1 = ref_mem[7'h10];
        step();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== exp_rd1) begin
            errors++; $display("FAIL midrst_prior: got rv1=%b rdata1=%h want 1 %h", rvalid1, rdata1, exp_rd1);
        end
    endtask

    task automatic test_latch();
        va = $urandom; vb = ~va;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 7'h03; wdata1 = va;
        step();
        req1 = 1'b0;
        step();
        req1 = 1'b1; addr1 = 7'h04; wdata1 = vb;
        step();
        req1 = 1'b0;
        ref_mem[3] = va; ref_mem[4] = vb;
        step();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 7'h03;
        step();
        checks++;
        if (gnt0 !== 1'b1 || dm_addr !== 7'h03) begin
            errors++; $display("FAIL latch_gnt: got gnt0=%b addr=%h want 1 03", gnt0, dm_addr);
        end
        addr0 = 7'h04;
        #1;
        checks++;
        if (dm_addr !== 7'h03) begin
            errors++; $display("FAIL latch_addr: got addr=%h want 03", dm_addr);
        end
        req0 = 1'b0;
        exp_rd0 = ref_mem[3];
        step();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== exp_rd0) begin
            errors++; $display("FAIL latch_data: got rv0=%b rdata0=%h want 1 %h", rvalid0, rdata0, exp_rd0);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; dly[p] = 0; waitc[p] = 0; pend[p] = 1'b0; pdat[p] = '0;
            cw[p] = 1'b0; ca[p] = '0; cd[p] = '0;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        for (int n = 0; n < 3000; n++) begin
            step();
            sg[0] = gnt0; sg[1] = gnt1; sv[0] = rvalid0; sv[1] = rvalid1; sr[0] = rdata0; sr[1] = rdata1;
            checks++;
            if (gnt0 && gnt1) begin
                errors++; $display("FAIL rand_gnt_excl: got both gnts at cycle %0d", n);
            end
            checks++;
            if (!gnt0 && !gnt1 && (dm_rd || dm_wr)) begin
                errors++; $display("FAIL rand_dm_idle: got rd=%b wr=%b with no gnt", dm_rd, dm_wr);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (sv[p] !== pend[p] || (pend[p] && sr[p] !== pdat[p])) begin
                    errors++; $display("FAIL rand_rvalid%0d: got v=%b d=%h want v=%b d=%h", p, sv[p], sr[p], pend[p], pdat[p]);
                end
                pend[p] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (sg[p]) begin
                    checks++;
                    if (!act[p] || dm_addr !== ca[p] || dm_wr !== cw[p] || dm_rd !== !cw[p] || (cw[p] && dm_wdata !== cd[p])) begin
                        errors++; $display("FAIL rand_cmd%0d: got act=%b addr=%h wr=%b rd=%b wd=%h want addr=%h wr=%b wd=%h",
                                           p, act[p], dm_addr, dm_wr, dm_rd, dm_wdata, ca[p], cw[p], cd[p]);
                    end
                    if (cw[p]) ref_mem[ca[p]] = cd[p];
                    else begin pend[p] = 1'b1; pdat[p] = ref_mem[ca[p]]; end
                    act[p] = 1'b0;
                    dly[p] = $urandom_range(0, 2);
                end else if (act[p]) begin
                    waitc[p]++;
                    checks++;
                    if (waitc[p] > 2) begin
                        errors++; $display("FAIL rand_wait%0d: got %0d cycles without gnt want <=2", p, waitc[p]);
                        act[p] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!act[p]) begin
                    if (dly[p] > 0) dly[p]--;
                    else if ($urandom_range(0, 3) != 0) begin
                        act[p] = 1'b1; cw[p] = 1'($urandom_range(0, 1)); cd[p] = $urandom; waitc[p] = 0;
                        ca[p] = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
                    end
                end
            end
            req0 = act[0]; wr0 = act[0] ? cw[0] : 1'($urandom_range(0, 1));
            addr0 = act[0] ? ca[0] : 7'($urandom); wdata0 = act[0] ? cd[0] : $urandom;
            req1 = act[1]; wr1 = act[1] ? cw[1] : 1'($urandom_range(0, 1));
            addr1 = act[1] ? ca[1] : 7'($urandom); wdata1 = act[1] ? cd[1] : $urandom;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        checks++;
        if (gnt0 || gnt1 || dm_rd || dm_wr) begin
            errors++; $display("FAIL rand_drain: got gnt=%b%b rd=%b wr=%b want all 0", gnt0, gnt1, dm_rd, dm_wr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_contention();
        test_p1_read();
        test_reset_mid();
        test_latch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
